// File: rtl/stream_pkg.sv
// Shared types and constants for the byte-stream source and its FIFO.
package stream_pkg;

    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_st_e;

    // level_o counts FIFO entries plus the output register: 0..DEPTH+1
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers; head is presented combinationally.
module stream_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              do_push;
    logic              do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (count_o == '0);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/stream_src.sv
// Valid/ready byte-stream source: write port -> FIFO -> registered output stage.
module stream_src
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en_i,
    input  logic [DATA_W-1:0]                wr_data_i,
    input  logic                             flush_i,
    output logic                             full_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [DATA_W-1:0]                data_o,
    output logic [level_width(DEPTH)-1:0]    level_o,
    output logic [CNT_W-1:0]                 sent_cnt_o,
    output logic                             ovf_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned LW = level_width(DEPTH);

    out_st_e           state_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [LW-1:0]     level_q;
    logic [CNT_W-1:0]  sent_cnt_q;
    logic              ovf_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_cnt;
    logic [CW-1:0]     fifo_cnt_d;

    logic              xfer;
    logic              out_free;
    logic              push_ok;
    logic              bypass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              valid_d;
    logic [LW-1:0]     level_d;

    stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (flush_i),
        .wdata_i (wr_data_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // The FIFO head wins over a same-cycle push; a push only bypasses when the FIFO is empty.
    always_comb begin
        xfer       = valid_q && ready_i;
        out_free   = !valid_q || xfer;
        push_ok    = wr_en_i && !fifo_full && !flush_i;
        bypass     = push_ok && fifo_empty && out_free;
        fifo_pop   = out_free && !fifo_empty && !flush_i;
        fifo_push  = push_ok && !bypass;
        load       = fifo_pop || bypass;
        load_data  = fifo_pop ? fifo_head : wr_data_i;
        valid_d    = load || (valid_q && !xfer);

        fifo_cnt_d = fifo_cnt;
        if (flush_i) begin
            fifo_cnt_d = '0;
        end else begin
            if (fifo_push) fifo_cnt_d = fifo_cnt_d + CW'(1);
            if (fifo_pop)  fifo_cnt_d = fifo_cnt_d - CW'(1);
        end
        level_d = LW'(fifo_cnt_d) + LW'(valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                OUT_EMPTY: begin
                    if (load) begin
                        state_q <= OUT_HOLD;
                        valid_q <= 1'b1;
                        data_q  <= load_data;
                    end
                end
                OUT_HOLD: begin
                    if (xfer) begin
                        if (load) begin
                            data_q <= load_data;
                        end else begin
                            state_q <= OUT_EMPTY;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= OUT_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q    <= '0;
            sent_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            level_q <= level_d;
            if (xfer) sent_cnt_q <= sent_cnt_q + CNT_W'(1);
            if (wr_en_i && fifo_full && !flush_i) ovf_q <= 1'b1;
        end
    end

    assign full_o     = fifo_full;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign level_o    = level_q;
    assign sent_cnt_o = sent_cnt_q;
    assign ovf_o      = ovf_q;

endmodule

// File: doc/stream_src.md
# stream_src

Byte-stream source that drives the valid/ready handshake toward a downstream sink (the receive-side stub driven by some_vip). Local logic pushes bytes through a simple write port into an internal FIFO. An output register then presents them on `valid_o`/`data_o` under strict handshake rules. The block is the transmitting end of the same 8-bit valid/ready link.

## Interface
Parameters:
- `DATA_W`, 8, payload width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2. Total capacity is DEPTH+1 (FIFO + output register).
- `CNT_W`, 16, width of the accepted-beat counter.

Ports:
- `clk`  in  1  clock. One clock domain; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en_i`  in  1  push `wr_data_i` this cycle.
- `wr_data_i`  in  DATA_W  byte to transmit.
- `flush_i`  in  1  discard all FIFO entries (does not affect the output register).
- `full_o`  out  1  FIFO holds DEPTH entries; pushes are dropped.
- `valid_o`  out  1  output register holds a beat.
- `ready_i`  in  1  sink accepts the beat.
- `data_o`  out  DATA_W  beat payload.
- `level_o`  out  $clog2(DEPTH+2)  FIFO entries plus output-register occupancy (0..DEPTH+1).
- `sent_cnt_o`  out  CNT_W  number of accepted beats, modulo 2^CNT_W.
- `ovf_o`  out  1  sticky flag: a push was dropped while full.

## Operation
- Handshake: a beat transfers on a rising edge where `valid_o && ready_i`.
- Once `valid_o` rises, it and `data_o` stay stable until transfer.
- `valid_o` never depends combinationally on `ready_i`.
- Output stage FSM:
  - States are EMPTY (`valid_o`=0) and HOLD (`valid_o`=1).
  - EMPTY→HOLD when a source byte is available: FIFO non-empty, or bypass.
  - HOLD→HOLD on transfer if another byte is available; the output register reloads.
  - HOLD→EMPTY on transfer with no byte available.
  - HOLD with no transfer: stays in HOLD.
- Bypass:
  - Applies when the FIFO is empty and the output register is empty or transferring this cycle.
  - In that case a push loads the output register directly and does not enter the FIFO.
- Ordering is strict FIFO. The FIFO head has priority over a simultaneous push.
- `full_o` is decoded from the registered FIFO count.
  - A push while `full_o`=1 is dropped and sets `ovf_o`, even if a transfer occurs the same cycle.
  - There is no pass-through when full.
- `flush_i`:
  - Empties the FIFO the next cycle.
  - A push in the same cycle is dropped, but `ovf_o` is not set.
  - A beat already in HOLD is kept and still transferred normally.
  - A transfer in the flush cycle does not reload from the FIFO.
- `sent_cnt_o` increments by 1 per transfer and wraps from 2^CNT_W−1 to 0.
- `level_o` updates the cycle after each push, transfer or flush. It never exceeds DEPTH+1.

## Timing
- Reset values:
  - `valid_o`=0, `data_o`=0, `full_o`=0, `level_o`=0, `sent_cnt_o`=0, `ovf_o`=0.
  - FIFO pointers are 0.
- Reset mid-operation discards all data, including a HOLD beat; `valid_o` drops the cycle after `rst`. The sink must tolerate this.
- Push-to-valid latency:
  - 1 cycle through bypass.
  - Through the FIFO: 1 cycle after the preceding beat transfers.
- Throughput: one beat per cycle while the sink holds `ready_i`=1 and data is available.
- All outputs are registered, except `full_o`, which is decoded from registered state.

## Structure
- Package `stream_pkg`:
  - `DATA_W` default constant.
  - Output-stage state enum `out_st_e {OUT_EMPTY, OUT_HOLD}`.
  - Helper function for the `level_o` width.
- Sub-module `stream_fifo`:
  - Synchronous FIFO with DEPTH entries and wrap-around pointers with an extra MSB.
  - Provides push/pop/flush, `full`, `empty` and count.
- `stream_src` contains the output FSM, bypass mux, counters and `ovf_o`.

## Test plan
- Reset, then push 0xA5 with `ready_i`=0:
  - `valid_o`=1 and `data_o`=0xA5 next cycle.
  - Both stay stable for 5 idle cycles.
  - Assert `ready_i`: transfer; `sent_cnt_o`=1; `valid_o`=0 next cycle.
- `ready_i`=0, push 0x01..0x06 on consecutive cycles (DEPTH=4):
  - `full_o`=1 after 0x05; 0x06 is dropped; `ovf_o`=1; `level_o`=5.
  - Draining yields 0x01..0x05 in order.
- `ready_i`=1 held, push 0x10..0x1F back-to-back:
  - 16 consecutive transfers, one per cycle, with `valid_o` continuously high.
  - `level_o` ≤1 throughout.
- Hold 0x30 with 3 bytes in the FIFO, pulse `flush_i`:
  - `level_o`=1; 0x30 still transfers; then `valid_o`=0.
- Random `ready_i` stall pattern with 1000 random pushes:
  - Scoreboard shows no loss, reorder or duplication.
  - `sent_cnt_o` matches transfers; `data_o` is stable whenever `valid_o && !ready_i`.
- Assert `rst` while in HOLD with a full FIFO:
  - Next cycle every output is 0 and `ovf_o` is cleared.
  - Push 0x77: `valid_o` next cycle with 0x77.
